// File: rtl/sync_debounce.sv
// Debounce filter for an already-synchronized glitchy level: accepts a level change only after
// STABLE_CYCLES identical consecutive samples, with edge pulses and a saturating rise counter.
module sync_debounce #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned EVT_W         = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             data_i,
  input  logic             enable_i,
  input  logic             evt_clr_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [EVT_W-1:0] evt_count_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_MAX  = '1;
  localparam bit DIRECT = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    LOW   = 2'd0,
    CHK_H = 2'd1,
    HIGH  = 2'd2,
    CHK_L = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic [EVT_W-1:0] evt_q;
  logic [EVT_W-1:0] evt_d;

  // Pulses default low so each lasts exactly the cycle after the accepting edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        LOW: begin
          cnt_q <= '0;
          if (enable_i && data_i) begin
            if (DIRECT) begin
              state_q <= HIGH;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              state_q <= CHK_H;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        CHK_H: begin
          if (!enable_i || !data_i) begin
            state_q <= LOW;
            cnt_q   <= '0;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          cnt_q <= '0;
          if (enable_i && !data_i) begin
            if (DIRECT) begin
              state_q <= LOW;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              state_q <= CHK_L;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        CHK_L: begin
          if (!enable_i || data_i) begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  // A clear landing in a rise_o cycle keeps that rise counted.
  always_comb begin
    evt_d = evt_q;
    if (evt_clr_i) begin
      evt_d = rise_q ? EVT_W'(1) : '0;
    end else if (rise_q && (evt_q != EVT_MAX)) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign level_o     = level_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign evt_count_o = evt_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench: STABLE_CYCLES=4/EVT_W=2 instance driven from a vector table, plus a
// STABLE_CYCLES=1 instance and reset corner sequences written out by hand.
module tb_sync_debounce;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       data_i;
  logic       enable_i;
  logic       evt_clr_i;

  logic       level_o, rise_o, fall_o;
  logic [1:0] evt_count_o;
  logic       level1_o, rise1_o, fall1_o;
  logic [7:0] evt1_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  sync_debounce #(.STABLE_CYCLES(4), .EVT_W(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .enable_i(enable_i),
    .evt_clr_i(evt_clr_i), .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .evt_count_o(evt_count_o)
  );

  sync_debounce #(.STABLE_CYCLES(1), .EVT_W(8)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .enable_i(enable_i),
    .evt_clr_i(evt_clr_i), .level_o(level1_o), .rise_o(rise1_o), .fall_o(fall1_o),
    .evt_count_o(evt1_count_o)
  );

  typedef struct {
    logic       d;
    logic       en;
    logic       clr;
    logic       lvl;
    logic       rise;
    logic       fall;
    logic [1:0] evt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input int n, input logic d, input logic en, input logic clr,
                     input logic lvl, input logic rise, input logic fall, input logic [1:0] evt);
    vec_t v;
    v.d = d; v.en = en; v.clr = clr; v.lvl = lvl; v.rise = rise; v.fall = fall; v.evt = evt;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive inputs just after an edge, clock once, compare 1 time unit after the next edge.
  task automatic step(input string tag, input logic d, input logic en, input logic clr,
                      input logic lvl, input logic rise, input logic fall, input logic [1:0] evt);
    data_i = d; enable_i = en; evt_clr_i = clr;
    @(posedge clk_i); #1;
    check({tag, " level"}, int'(level_o), int'(lvl));
    check({tag, " rise"},  int'(rise_o),  int'(rise));
    check({tag, " fall"},  int'(fall_o),  int'(fall));
    check({tag, " evt"},   int'(evt_count_o), int'(evt));
  endtask

  task automatic step1(input string tag, input logic d, input logic en,
                       input logic lvl, input logic rise, input logic fall, input logic [7:0] evt);
    data_i = d; enable_i = en; evt_clr_i = 1'b0;
    @(posedge clk_i); #1;
    check({tag, " level1"}, int'(level1_o), int'(lvl));
    check({tag, " rise1"},  int'(rise1_o),  int'(rise));
    check({tag, " fall1"},  int'(fall1_o),  int'(fall));
    check({tag, " evt1"},   int'(evt1_count_o), int'(evt));
  endtask

  initial begin
    reset_i = 1'b0; data_i = 1'b0; enable_i = 1'b1; evt_clr_i = 1'b0;

    // d en clr | level rise fall evt
    add(1, 0,1,0, 0,0,0,0);
    add(3, 1,1,0, 0,0,0,0);   // clean rise: samples 1..3
    add(1, 1,1,0, 1,1,0,0);   // 4th high sample accepted
    add(2, 1,1,0, 1,0,0,1);
    add(3, 0,1,0, 1,0,0,1);
    add(1, 0,1,0, 0,0,1,1);
    add(1, 0,1,0, 0,0,0,1);
    add(3, 1,1,0, 0,0,0,1);   // 3-sample burst, then a glitch
    add(1, 0,1,0, 0,0,0,1);
    add(3, 1,1,0, 0,0,0,1);
    add(1, 1,1,0, 1,1,0,1);
    add(1, 1,1,0, 1,0,0,2);
    for (int k = 0; k < 3; k++) begin   // toggling never moves the level
      add(1, 0,1,0, 1,0,0,2);
      add(1, 1,1,0, 1,0,0,2);
    end
    add(10, 0,0,0, 1,0,0,2);  // disabled in HIGH holds level
    add(3, 0,1,0, 1,0,0,2);
    add(1, 0,1,0, 0,0,1,2);
    add(1, 0,1,0, 0,0,0,2);
    add(2, 1,1,0, 0,0,0,2);
    add(1, 1,0,0, 0,0,0,2);   // disable aborts CHK_H
    add(3, 1,1,0, 0,0,0,2);
    add(1, 1,1,0, 1,1,0,2);
    add(1, 1,1,0, 1,0,0,3);
    add(3, 0,1,0, 1,0,0,3);
    add(1, 0,1,0, 0,0,1,3);
    add(3, 1,1,0, 0,0,0,3);
    add(1, 1,1,0, 1,1,0,3);
    add(1, 1,1,0, 1,0,0,3);   // saturated
    add(3, 0,1,0, 1,0,0,3);
    add(1, 0,1,0, 0,0,1,3);
    add(3, 1,1,0, 0,0,0,3);
    add(1, 1,1,0, 1,1,0,3);
    add(1, 1,1,1, 1,0,0,1);   // clear during rise_o loads 1
    add(1, 1,1,1, 1,0,0,0);
    add(1, 1,1,0, 1,0,0,0);

    #12;
    check("reset level", int'(level_o), 0);
    check("reset rise",  int'(rise_o), 0);
    check("reset fall",  int'(fall_o), 0);
    check("reset evt",   int'(evt_count_o), 0);
    check("reset level1", int'(level1_o), 0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].d, vecs[i].en, vecs[i].clr,
           vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].evt);
    end

    // Reset in the middle of a rise check, with a non-zero event count.
    for (int i = 0; i < 3; i++) step("pre_low", 0,1,0, 1,0,0,0);
    step("pre_fall", 0,1,0, 0,0,1,0);
    for (int i = 0; i < 3; i++) step("pre_high", 1,1,0, 0,0,0,0);
    step("pre_rise", 1,1,0, 1,1,0,0);
    step("pre_cnt", 1,1,0, 1,0,0,1);
    for (int i = 0; i < 3; i++) step("pre_low2", 0,1,0, 1,0,0,1);
    step("pre_fall2", 0,1,0, 0,0,1,1);
    for (int i = 0; i < 3; i++) step("chk_h", 1,1,0, 0,0,0,1);
    reset_i = 1'b0;
    #2;
    check("midreset level", int'(level_o), 0);
    check("midreset rise",  int'(rise_o), 0);
    check("midreset fall",  int'(fall_o), 0);
    check("midreset evt",   int'(evt_count_o), 0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("post_rst%0d", i), 1,1,0, 0,0,0,0);
    step("post_rst_rise", 1,1,0, 1,1,0,0);
    step("post_rst_cnt",  1,1,0, 1,0,0,1);

    // STABLE_CYCLES=1 instance: level follows data one cycle late.
    reset_i = 1'b0; data_i = 1'b0;
    #2;
    check("rst1 level1", int'(level1_o), 0);
    check("rst1 evt1",   int'(evt1_count_o), 0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    step1("t1", 1,1, 1,1,0, 8'd0);
    step1("t2", 0,1, 0,0,1, 8'd1);
    step1("t3", 1,1, 1,1,0, 8'd1);
    step1("t4", 0,1, 0,0,1, 8'd2);
    step1("t5", 1,1, 1,1,0, 8'd2);
    step1("t6", 0,1, 0,0,1, 8'd3);
    step1("t7_dis", 1,0, 0,0,0, 8'd3);
    step1("t8", 1,1, 1,1,0, 8'd3);
    step1("t9", 1,1, 1,0,0, 8'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, SHALL be the number of consecutive identical samples required to accept a level change; legal range 1..65535.
REQ-002 Parameter EVT_W, default 8, SHALL be the width of the rising-event counter; legal range 1..32.
REQ-003 Local CNT_W SHALL equal $clog2(STABLE_CYCLES+1).
REQ-004 clk_i  input  1  destination-domain clock.
REQ-005 reset_i  input  1  reset, asynchronous, active-low.
REQ-006 data_i  input  1  level already synchronized into clk_i by the upstream synchronizer chain; treated as glitchy.
REQ-007 enable_i  input  1  filter enable; 0 freezes accepted level.
REQ-008 evt_clr_i  input  1  synchronous clear of evt_count_o.
REQ-009 level_o  output  1  debounced, accepted level.
REQ-010 rise_o  output  1  one-cycle pulse on accepted 0->1 change.
REQ-011 fall_o  output  1  one-cycle pulse on accepted 1->0 change.
REQ-012 evt_count_o  output  EVT_W  saturating count of rise_o pulses.

Function
REQ-013 FSM SHALL have four states: LOW, CHK_H, HIGH, CHK_L, plus a CNT_W-bit stability counter cnt.
REQ-014 LOW: enable_i=1 and data_i=1 -> CHK_H with cnt=1; otherwise stay, cnt=0.
REQ-015 CHK_H: data_i=0 -> LOW, cnt=0 (glitch rejected, no pulse); data_i=1 and cnt<STABLE_CYCLES-1 -> cnt+1; data_i=1 and cnt==STABLE_CYCLES-1 -> HIGH, cnt=0.
REQ-016 HIGH and CHK_L SHALL mirror REQ-014/015 with data_i polarity inverted, terminating in LOW.
REQ-017 STABLE_CYCLES=1: LOW->HIGH and HIGH->LOW SHALL occur directly on the first differing sample; CHK states unused.
REQ-018 Latency: with data_i sampled at its new value on STABLE_CYCLES consecutive edges, level_o SHALL change immediately after the last of those edges; any differing sample in between restarts the count from zero.
REQ-019 level_o SHALL be a registered output: 1 in HIGH and CHK_L, 0 in LOW and CHK_H.
REQ-020 rise_o SHALL be 1 for exactly the cycle in which level_o first reads 1; fall_o likewise for first 0; never both high.
REQ-021 enable_i=0: LOW/HIGH hold; CHK_H -> LOW and CHK_L -> HIGH, cnt=0; no pulses generated.
REQ-022 evt_count_o SHALL increment by 1 on each rise_o cycle and saturate at 2^EVT_W-1 (no wrap).
REQ-023 evt_clr_i=1 SHALL load 0, except when coincident with rise_o it SHALL load 1.
REQ-024 data_i changing every cycle indefinitely SHALL never change level_o (for STABLE_CYCLES>=2).

Reset
REQ-025 reset_i=0 SHALL asynchronously force state LOW, cnt=0, level_o=0, rise_o=0, fall_o=0, evt_count_o=0.
REQ-026 Reset asserted mid-CHK_H or CHK_L SHALL discard partial count; after deassertion the filter restarts from LOW regardless of data_i.
REQ-027 First edge after deassertion with data_i=1 SHALL be counted as sample 1 of a rise check.

Verification (STABLE_CYCLES=4, EVT_W=2 unless noted)
REQ-028 data_i 0->1 held 6 cycles -> level_o=1 after 4th high edge, rise_o one cycle, evt_count_o=1.
REQ-029 data_i high 3 cycles, low 1, high 4 -> no pulse after first burst; level_o=1 only after 4th edge of second burst.
REQ-030 Four accepted rises -> evt_count_o 1,2,3,3 (saturated); evt_clr_i coincident with 5th rise -> 1.
REQ-031 In HIGH, enable_i=0 then data_i=0 for 10 cycles -> level_o stays 1, fall_o never asserts; enable_i=1 -> fall after 4 more low samples.
REQ-032 reset_i pulsed low during CHK_H at cnt=3 -> all outputs 0 immediately; data_i=1 afterwards requires full 4 samples.
REQ-033 STABLE_CYCLES=1: data_i toggling each cycle -> level_o follows data_i one cycle late, rise_o/fall_o alternate every cycle.
